// File: rtl/efpga_pkg.sv
`default_nettype none
// ============================================================================
// Module  : efpga_pkg
// Brief   : Shared FSM state type and encodings for the eFPGA accelerator bridge.
// Revision: 1.0
// ============================================================================
package efpga_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } efpga_state_e;

  localparam logic [1:0] EFPGA_OP_0 = 2'd0;
  localparam logic [1:0] EFPGA_OP_1 = 2'd1;
  localparam logic [1:0] EFPGA_OP_2 = 2'd2;
  localparam logic [1:0] EFPGA_OP_3 = 2'd3;

  localparam logic [3:0] EFPGA_DELAY_HANDSHAKE = 4'd0;

endpackage
`default_nettype wire

// File: rtl/efpga_wait_counter.sv
`default_nettype none
// ============================================================================
// Module  : efpga_wait_counter
// Brief   : Loadable saturating wait counter with fixed-delay and timeout compares.
// Revision: 1.0
// ============================================================================
module efpga_wait_counter
  import efpga_pkg::*;
#(
  parameter int TimeoutCycles = 256,
  parameter int CntWidth      = $clog2(TimeoutCycles + 1)
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic       i_inc,
  input  logic [3:0] i_delay,
  output logic       o_delay_match,
  output logic       o_timeout_match
);

  // At least 4 bits so every programmable delay (up to 15) remains reachable.
  localparam int CW = (CntWidth > 4) ? CntWidth : 4;

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_delay_m1;

  assign w_delay_m1 = CW'(i_delay) - CW'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {CW{1'b1}})) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_delay_match   = (i_delay != EFPGA_DELAY_HANDSHAKE) && (r_cnt == w_delay_m1);
  assign o_timeout_match = (r_cnt == CW'(TimeoutCycles - 1));

endmodule
`default_nettype wire

// File: rtl/efpga_accel_bridge.sv
`default_nettype none
// ============================================================================
// Module  : efpga_accel_bridge
// Brief   : Core-to-eFPGA bridge: launches one fabric op, completes it by fixed
//           latency or done handshake with timeout, and returns registered results.
// Revision: 1.0
// ============================================================================
module efpga_accel_bridge
  import efpga_pkg::*;
#(
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 256,
  parameter int CntWidth      = $clog2(TimeoutCycles + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 core_en_i,
  input  logic                 core_write_strobe_i,
  input  logic [1:0]           core_operator_i,
  input  logic [3:0]           core_delay_i,
  input  logic [DataWidth-1:0] core_operand_a_i,
  input  logic [DataWidth-1:0] core_operand_b_i,
  output logic [DataWidth-1:0] core_result_a_o,
  output logic [DataWidth-1:0] core_result_b_o,
  output logic [DataWidth-1:0] core_result_c_o,
  output logic                 core_fpga_done_o,
  output logic [DataWidth-1:0] fab_operand_a_o,
  output logic [DataWidth-1:0] fab_operand_b_o,
  output logic [1:0]           fab_operator_o,
  output logic                 fab_start_o,
  input  logic [DataWidth-1:0] fab_result_a_i,
  input  logic [DataWidth-1:0] fab_result_b_i,
  input  logic [DataWidth-1:0] fab_result_c_i,
  input  logic                 fab_done_i,
  output logic                 busy_o,
  output logic                 err_o
);

  efpga_state_e         r_state;
  efpga_state_e         w_state_d;
  logic [DataWidth-1:0] r_op_a;
  logic [DataWidth-1:0] r_op_b;
  logic [1:0]           r_operator;
  logic [3:0]           r_delay;
  logic [DataWidth-1:0] r_res_a;
  logic [DataWidth-1:0] r_res_b;
  logic [DataWidth-1:0] r_res_c;
  logic                 r_err;

  logic w_accept;
  logic w_in_wait;
  logic w_fixed;
  logic w_capture;
  logic w_timeout;
  logic w_delay_match;
  logic w_timeout_match;

  efpga_wait_counter #(
    .TimeoutCycles (TimeoutCycles),
    .CntWidth      (CntWidth)
  ) u_wait_counter (
    .i_clk           (clk_i),
    .i_rst_n         (rst_ni),
    .i_load          (r_state == ST_LAUNCH),
    .i_inc           (w_in_wait),
    .i_delay         (r_delay),
    .o_delay_match   (w_delay_match),
    .o_timeout_match (w_timeout_match)
  );

  // DONE accepts a launch like IDLE so the core can issue back-to-back ops.
  assign w_accept  = core_en_i && core_write_strobe_i &&
                     ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_in_wait = (r_state == ST_WAIT);
  assign w_fixed   = (r_delay != EFPGA_DELAY_HANDSHAKE);
  assign w_capture = w_in_wait && core_en_i &&
                     (w_fixed ? w_delay_match : fab_done_i);
  assign w_timeout = w_in_wait && core_en_i && !w_fixed && !fab_done_i && w_timeout_match;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d        = r_state;
    fab_start_o      = 1'b0;
    busy_o           = 1'b0;
    core_fpga_done_o = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_d = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        fab_start_o = 1'b1;
        busy_o      = 1'b1;
        w_state_d   = core_en_i ? ST_WAIT : ST_IDLE;
      end
      ST_WAIT: begin
        busy_o = 1'b1;
        if (!core_en_i)                    w_state_d = ST_IDLE;
        else if (w_capture || w_timeout)   w_state_d = ST_DONE;
      end
      ST_DONE: begin
        core_fpga_done_o = 1'b1;
        w_state_d        = w_accept ? ST_LAUNCH : ST_IDLE;
      end
      default: w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_operator <= '0;
      r_delay    <= '0;
      r_res_a    <= '0;
      r_res_b    <= '0;
      r_res_c    <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op_a     <= core_operand_a_i;
        r_op_b     <= core_operand_b_i;
        r_operator <= core_operator_i;
        r_delay    <= core_delay_i;
        r_err      <= 1'b0;
      end
      if (w_capture) begin
        r_res_a <= fab_result_a_i;
        r_res_b <= fab_result_b_i;
        r_res_c <= fab_result_c_i;
      end else if (w_timeout) begin
        r_res_a <= '0;
        r_res_b <= '0;
        r_res_c <= '0;
        r_err   <= 1'b1;
      end
    end
  end

  assign core_result_a_o = r_res_a;
  assign core_result_b_o = r_res_b;
  assign core_result_c_o = r_res_c;
  assign fab_operand_a_o = r_op_a;
  assign fab_operand_b_o = r_op_b;
  assign fab_operator_o  = r_operator;
  assign err_o           = r_err;

endmodule
`default_nettype wire

// File: tb/tb_efpga_accel_bridge.sv
`default_nettype none
// ============================================================================
// Module  : tb_efpga_accel_bridge
// Brief   : Directed self-checking bench for efpga_accel_bridge with a result scoreboard.
// Revision: 1.0
// ============================================================================
module tb_efpga_accel_bridge;
  import efpga_pkg::*;

  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          strobe = 1'b0;
  logic [1:0]    op = 2'd0;
  logic [3:0]    dly = 4'd0;
  logic [DW-1:0] opa = '0;
  logic [DW-1:0] opb = '0;
  logic [DW-1:0] res_a, res_b, res_c;
  logic          done;
  logic [DW-1:0] f_opa, f_opb;
  logic [1:0]    f_op;
  logic          f_start;
  logic [DW-1:0] fr_a = '0;
  logic [DW-1:0] fr_b = '0;
  logic [DW-1:0] fr_c = '0;
  logic          f_done = 1'b0;
  logic          busy, err;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] c;
    logic          e;
  } exp_t;
  exp_t sb[$];

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int cyc     = 0;

  efpga_accel_bridge #(
    .DataWidth     (DW),
    .TimeoutCycles (TO)
  ) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .core_en_i           (en),
    .core_write_strobe_i (strobe),
    .core_operator_i     (op),
    .core_delay_i        (dly),
    .core_operand_a_i    (opa),
    .core_operand_b_i    (opb),
    .core_result_a_o     (res_a),
    .core_result_b_o     (res_b),
    .core_result_c_o     (res_c),
    .core_fpga_done_o    (done),
    .fab_operand_a_o     (f_opa),
    .fab_operand_b_o     (f_opb),
    .fab_operator_o      (f_op),
    .fab_start_o         (f_start),
    .fab_result_a_i      (fr_a),
    .fab_result_b_i      (fr_b),
    .fab_result_c_i      (fr_c),
    .fab_done_i          (f_done),
    .busy_o              (busy),
    .err_o               (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [DW-1:0] c, input logic e);
    exp_t x;
    x.a = a; x.b = b; x.c = c; x.e = e;
    sb.push_back(x);
  endtask

  task automatic sb_check(input string tag);
    exp_t x;
    chk({tag, "_sb_nonempty"}, DW'(sb.size() != 0), 1);
    if (sb.size() != 0) begin
      x = sb.pop_front();
      chk({tag, "_res_a"}, res_a, x.a);
      chk({tag, "_res_b"}, res_b, x.b);
      chk({tag, "_res_c"}, res_c, x.c);
      chk({tag, "_err"},   DW'(err), DW'(x.e));
    end
  endtask

  // Strobe is driven in cycle 0; returns positioned in cycle 1 with strobe low.
  task automatic launch(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [1:0] o, input logic [3:0] d);
    en = 1'b1; strobe = 1'b1; opa = a; opb = b; op = o; dly = d;
    cyc = 0;
    step();
    strobe = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_cyc);
    while (!done && cyc < 64) step();
    chk({tag, "_done_cycle"}, DW'(cyc), DW'(exp_cyc));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_res_a"}, res_a, '0);
    chk({tag, "_res_b"}, res_b, '0);
    chk({tag, "_res_c"}, res_c, '0);
    chk({tag, "_fab_a"}, f_opa, '0);
    chk({tag, "_fab_b"}, f_opb, '0);
    chk({tag, "_flags"}, DW'({done, f_start, busy, err, f_op}), '0);
  endtask

  initial begin
    // Reset values
    #3;
    chk_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();

    // Fixed latency D=4; correct fabric data only on the capture cycle 5
    push(32'h8, 32'h2, 32'hF, 1'b0);
    launch(32'h5, 32'h3, EFPGA_OP_1, 4'd4);
    chk("fix_start", DW'(f_start), 1);
    chk("fix_fab_a", f_opa, 32'h5);
    chk("fix_fab_b", f_opb, 32'h3);
    chk("fix_fab_op", DW'(f_op), DW'(EFPGA_OP_1));
    chk("fix_busy", DW'(busy), 1);
    for (int c = 2; c <= 5; c++) begin
      step();
      f_done = (c == 2);
      fr_a = (c == 5) ? 32'h8 : 32'hDEAD0000;
      fr_b = (c == 5) ? 32'h2 : 32'hDEAD0001;
      fr_c = (c == 5) ? 32'hF : 32'hDEAD0002;
      chk("fix_no_early_done", DW'({done, f_start}), 0);
    end
    step();
    f_done = 1'b0;
    chk("fix_done_c6", DW'(done), 1);
    chk("fix_busy_in_done", DW'(busy), 0);
    sb_check("fix");
    step();
    chk("fix_done_one_cycle", DW'(done), 0);

    // Handshake: fab_done in LAUNCH ignored, accepted in cycle 5
    push(32'hAAAA0001, 32'hAAAA0002, 32'hAAAA0003, 1'b0);
    fr_a = 32'hAAAA0001; fr_b = 32'hAAAA0002; fr_c = 32'hAAAA0003;
    launch(32'hA1, 32'hB1, EFPGA_OP_2, EFPGA_DELAY_HANDSHAKE);
    f_done = 1'b1;
    for (int c = 2; c <= 5; c++) begin
      step();
      f_done = (c == 5);
      chk("hs_no_early_done", DW'(done), 0);
    end
    step();
    f_done = 1'b0;
    chk("hs_done_c6", DW'(done), 1);
    sb_check("hs");
    fr_a = 32'h1; fr_b = 32'h2; fr_c = 32'h3;
    repeat (3) step();
    chk("hs_hold_a", res_a, 32'hAAAA0001);
    chk("hs_hold_c", res_c, 32'hAAAA0003);

    // Strobe while busy is ignored, then abort by dropping enable
    launch(32'h11, 32'h22, EFPGA_OP_2, 4'd3);
    fr_a = 32'hBAD0; fr_b = 32'hBAD1; fr_c = 32'hBAD2;
    step();
    strobe = 1'b1; opa = 32'h99;
    step();
    strobe = 1'b0;
    chk("busy_strobe_ignored", f_opa, 32'h11);
    chk("abort_busy_before", DW'(busy), 1);
    en = 1'b0;
    step();
    chk("abort_idle", DW'(busy), 0);
    repeat (4) begin
      chk("abort_no_done", DW'(done), 0);
      step();
    end
    chk("abort_keep_a", res_a, 32'hAAAA0001);
    chk("abort_keep_b", res_b, 32'hAAAA0002);
    chk("abort_err", DW'(err), 0);

    // Timeout with TimeoutCycles=8: done in cycle 10, results zeroed, err set
    f_done = 1'b0;
    push('0, '0, '0, 1'b1);
    launch(32'h7, 32'h8, EFPGA_OP_3, EFPGA_DELAY_HANDSHAKE);
    wait_done("to", TO + 2);
    sb_check("to");
    // Back-to-back launch in the DONE cycle clears err
    push(32'h31, 32'h32, 32'h33, 1'b0);
    fr_a = 32'h31; fr_b = 32'h32; fr_c = 32'h33;
    launch(32'h123, 32'h456, EFPGA_OP_0, 4'd2);
    chk("b2b_start", DW'(f_start), 1);
    chk("b2b_fab_a", f_opa, 32'h123);
    chk("b2b_fab_op", DW'(f_op), DW'(EFPGA_OP_0));
    chk("b2b_err_cleared", DW'(err), 0);
    wait_done("b2b", 4);
    sb_check("b2b");
    step();
    chk("b2b_done_one_cycle", DW'(done), 0);

    // Asynchronous reset in WAIT
    launch(32'h55, 32'h66, EFPGA_OP_1, 4'd5);
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_no_done", DW'({done, busy}), 0);

    // Clean handshake operation after reset
    push(32'hC1, 32'hC2, 32'hC3, 1'b0);
    fr_a = 32'hC1; fr_b = 32'hC2; fr_c = 32'hC3;
    launch(32'h77, 32'h88, EFPGA_OP_3, EFPGA_DELAY_HANDSHAKE);
    step();
    step();
    f_done = 1'b1;
    step();
    f_done = 1'b0;
    chk("post_rst_done_c4", DW'(done), 1);
    sb_check("post_rst");
    chk("sb_drained", DW'(sb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
